// File: rtl/spectrum_bar_buffer.sv
`default_nettype none
// ============================================================================
// Module   : spectrum_bar_buffer
// Purpose  : Double-buffered FFT bar-height store with peak-hold decay.
// Revision : 1.0  initial release
// ============================================================================
module spectrum_bar_buffer #(
  parameter int unsigned FFT_N   = 128,
  parameter int unsigned BIN_NUM = 64,
  parameter int unsigned SHIFT   = 6,
  parameter int unsigned MAX_H   = 272,
  parameter int unsigned DECAY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fft_data,
  input  logic        fft_sop,
  input  logic        fft_eop,
  input  logic        fft_valid,
  input  logic [5:0]  rd_addr,
  output logic [8:0]  rd_data,
  output logic        frame_done,
  output logic        frame_err
);

  localparam int unsigned CNT_W  = (FFT_N > 1)   ? $clog2(FFT_N)   : 1;
  localparam int unsigned ADDR_W = (BIN_NUM > 1) ? $clog2(BIN_NUM) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FFT_N - 1);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_COLLECT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             over_q, over_d;

  logic             w_start, w_cont, w_ovf, w_accept, w_last;
  logic [CNT_W-1:0] w_idx;
  logic             w_store, w_commit, w_err;
  logic [15:0]      w_shifted;
  logic [8:0]       w_h;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [8:0]        wr_h_q;
  logic              commit_q, err_q;
  logic              bank_sel_q, committed_q;
  logic              frame_done_q, frame_err_q;
  logic [8:0]        rd_data_q, rd_data_d;

  logic [8:0] bank0_q [BIN_NUM];
  logic [8:0] bank1_q [BIN_NUM];

  logic [8:0] w_old, w_dec, w_new;

  // A sop beat always starts a frame at index 0, whatever state we are in.
  assign w_start   = fft_valid & fft_sop;
  assign w_cont    = fft_valid & ~fft_sop & (state_q == S_COLLECT) & ~over_q;
  assign w_ovf     = fft_valid & ~fft_sop & (state_q == S_COLLECT) & over_q;
  assign w_accept  = w_start | w_cont;
  assign w_idx     = w_start ? '0 : cnt_q;
  assign w_last    = (w_idx == LAST_IDX);
  assign w_shifted = fft_data >> SHIFT;
  assign w_h       = (w_shifted > 16'(MAX_H)) ? 9'(MAX_H) : w_shifted[8:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      over_q  <= over_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    over_d  = over_q;
    if ((w_accept && fft_eop) || w_ovf) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      over_d  = 1'b0;
    end else if (w_accept) begin
      state_d = S_COLLECT;
      cnt_d   = w_idx + CNT_W'(1);
      over_d  = w_last;
    end
  end

  always_comb begin
    w_store  = w_accept && (32'(w_idx) < BIN_NUM);
    w_commit = w_accept && fft_eop && w_last;
    w_err    = (w_accept && fft_eop && !w_last) || w_ovf ||
               (w_start && (state_q == S_COLLECT));
  end

  // Peak-hold reference is the displayed (front) bank, which only changes on commit.
  assign w_old = committed_q ? (bank_sel_q ? bank1_q[wr_addr_q] : bank0_q[wr_addr_q]) : 9'd0;
  assign w_dec = (w_old > 9'(DECAY)) ? (w_old - 9'(DECAY)) : 9'd0;
  assign w_new = (wr_h_q > w_dec) ? wr_h_q : w_dec;

  always_ff @(posedge clk) begin
    if (!rst && wr_en_q) begin
      if (bank_sel_q) bank0_q[wr_addr_q] <= w_new;
      else            bank1_q[wr_addr_q] <= w_new;
    end
  end

  always_comb begin
    rd_data_d = 9'd0;
    if (committed_q && (32'(rd_addr) < BIN_NUM)) begin
      rd_data_d = bank_sel_q ? bank1_q[ADDR_W'(rd_addr)] : bank0_q[ADDR_W'(rd_addr)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_h_q       <= 9'd0;
      commit_q     <= 1'b0;
      err_q        <= 1'b0;
      bank_sel_q   <= 1'b0;
      committed_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rd_data_q    <= 9'd0;
    end else begin
      wr_en_q      <= w_store;
      wr_addr_q    <= ADDR_W'(w_idx);
      wr_h_q       <= w_h;
      commit_q     <= w_commit;
      err_q        <= w_err;
      if (commit_q) begin
        bank_sel_q  <= ~bank_sel_q;
        committed_q <= 1'b1;
      end
      frame_done_q <= commit_q;
      frame_err_q  <= err_q;
      rd_data_q    <= rd_data_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spectrum_bar_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spectrum_bar_buffer
// Purpose  : Randomised self-checking bench with a frame-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_spectrum_bar_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] fft_data = '0;
  logic        fft_sop = 1'b0;
  logic        fft_eop = 1'b0;
  logic        fft_valid = 1'b0;
  logic [5:0]  rd_addr = '0;
  logic [8:0]  rd_data;
  logic        frame_done;
  logic        frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  int          mfront [64];
  bit          mcomm = 1'b0;
  logic [15:0] fdata [128];

  always #5 clk = ~clk;

  spectrum_bar_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .fft_data   (fft_data),
    .fft_sop    (fft_sop),
    .fft_eop    (fft_eop),
    .fft_valid  (fft_valid),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always @(negedge clk) begin
    if (frame_done) done_cnt <= done_cnt + 1;
    if (frame_err)  err_cnt  <= err_cnt + 1;
  end

  // Reference: a fully received frame replaces the display with peak-held heights.
  task automatic model_commit();
    for (int b = 0; b < 64; b++) begin
      int h, old, dec;
      h   = int'(fdata[b]) >> 6;
      if (h > 272) h = 272;
      old = mcomm ? mfront[b] : 0;
      dec = (old > 4) ? old - 4 : 0;
      mfront[b] = (h > dec) ? h : dec;
    end
    mcomm = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; fft_valid = 1'b0; fft_sop = 1'b0; fft_eop = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mcomm = 1'b0;
  endtask

  task automatic drive_beat(input logic [15:0] d, input logic s, input logic e);
    @(negedge clk);
    fft_data = d; fft_sop = s; fft_eop = e; fft_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      fft_valid = 1'b0; fft_sop = 1'b0; fft_eop = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_frame(input int n, input int eop_at, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        fft_valid = 1'b0;
        fft_sop   = 1'($urandom_range(0, 1));
        fft_eop   = 1'($urandom_range(0, 1));
        fft_data  = 16'($urandom);
      end
      drive_beat(fdata[i], i == 0, i == eop_at);
    end
  endtask

  task automatic fill_random(input int maxv);
    for (int i = 0; i < 128; i++) fdata[i] = 16'($urandom_range(0, maxv));
  endtask

  task automatic read_bin(input int a, output int v);
    @(negedge clk);
    rd_addr = 6'(a);
    @(posedge clk); #1;
    v = int'(rd_data);
  endtask

  task automatic check_bins(input string tag);
    int v, exp;
    for (int b = 0; b < 64; b++) begin
      read_bin(b, v);
      exp = mcomm ? mfront[b] : 0;
      n_cmp++;
      if (v !== exp) begin
        n_bad++;
        $display("FAIL %s bin %0d: rd_data=%0d expected=%0d", tag, b, v, exp);
      end
    end
  endtask

  task automatic check_counts(input string tag, input int d0, input int e0, input int dd, input int de);
    n_cmp++;
    if (done_cnt - d0 !== dd) begin
      n_bad++;
      $display("FAIL %s frame_done pulses: got %0d expected %0d", tag, done_cnt - d0, dd);
    end
    n_cmp++;
    if (err_cnt - e0 !== de) begin
      n_bad++;
      $display("FAIL %s frame_err pulses: got %0d expected %0d", tag, err_cnt - e0, de);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk); #1;
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_bad++; $display("FAIL reset frame_done: got %b expected 0", frame_done);
    end
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_bad++; $display("FAIL reset frame_err: got %b expected 0", frame_err);
    end
    check_bins("reset");
  endtask

  task automatic test_ramp();
    int v, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    for (int i = 0; i < 128; i++) fdata[i] = 16'(i * 64);
    for (int i = 0; i < 127; i++) drive_beat(fdata[i], i == 0, 1'b0);
    drive_beat(fdata[127], 1'b0, 1'b1);
    @(posedge clk); #1;
    fft_valid = 1'b0; fft_eop = 1'b0;
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_bad++; $display("FAIL ramp done_early: got %b expected 0", frame_done);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_bad++; $display("FAIL ramp done_pulse: got %b expected 1", frame_done);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_bad++; $display("FAIL ramp done_width: got %b expected 0", frame_done);
    end
    model_commit();
    idle(3);
    check_counts("ramp", d0, e0, 1, 0);
    read_bin(10, v);
    n_cmp++;
    if (v !== 10) begin
      n_bad++; $display("FAIL ramp bin10: rd_data=%0d expected=10", v);
    end
    read_bin(63, v);
    n_cmp++;
    if (v !== 63) begin
      n_bad++; $display("FAIL ramp bin63: rd_data=%0d expected=63", v);
    end
  endtask

  task automatic test_random_frames();
    int d0, e0;
    for (int f = 0; f < 4; f++) begin
      d0 = done_cnt; e0 = err_cnt;
      fill_random(20000);
      drive_frame(128, 127, 1'b1);
      model_commit();
      idle(4);
      check_counts("random", d0, e0, 1, 0);
      check_bins("random");
    end
  endtask

  task automatic test_saturation();
    int v;
    for (int i = 0; i < 128; i++) fdata[i] = 16'hFFFF;
    drive_frame(128, 127, 1'b0);
    model_commit();
    idle(4);
    for (int b = 0; b < 64; b += 9) begin
      read_bin(b, v);
      n_cmp++;
      if (v !== 272) begin
        n_bad++; $display("FAIL saturation bin %0d: rd_data=%0d expected=272", b, v);
      end
    end
    check_bins("saturation");
  endtask

  task automatic test_decay();
    int v;
    do_reset();
    for (int i = 0; i < 128; i++) fdata[i] = 16'(100 << 6);
    drive_frame(128, 127, 1'b0);
    model_commit();
    for (int i = 0; i < 128; i++) fdata[i] = 16'h0000;
    for (int f = 1; f <= 25; f++) begin
      drive_frame(128, 127, 1'b0);
      model_commit();
      if (f == 1 || f == 2 || f == 25) begin
        idle(4);
        read_bin($urandom_range(0, 63), v);
        n_cmp++;
        if (v !== 100 - 4 * f) begin
          n_bad++; $display("FAIL decay frame %0d: rd_data=%0d expected=%0d", f, v, 100 - 4 * f);
        end
      end
    end
    idle(4);
    check_bins("decay");
  endtask

  task automatic test_early_eop();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    fill_random(30000);
    drive_frame(51, 50, 1'b1);
    idle(4);
    check_counts("early_eop", d0, e0, 0, 1);
    check_bins("early_eop");
  endtask

  task automatic test_restart();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    for (int i = 0; i < 70; i++) drive_beat(16'($urandom), i == 0, 1'b0);
    fill_random(20000);
    drive_frame(128, 127, 1'b0);
    model_commit();
    idle(4);
    check_counts("restart", d0, e0, 1, 1);
    check_bins("restart");
  endtask

  task automatic test_overflow();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    fill_random(30000);
    drive_frame(128, -1, 1'b1);
    drive_beat(16'($urandom), 1'b0, 1'b0);
    idle(4);
    check_counts("overflow", d0, e0, 0, 1);
    check_bins("overflow");
  endtask

  task automatic test_sop_eop();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    drive_beat(16'($urandom), 1'b1, 1'b1);
    idle(4);
    check_counts("sop_eop", d0, e0, 0, 1);
  endtask

  task automatic test_back_to_back();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    fill_random(25000);
    drive_frame(128, 127, 1'b0);
    model_commit();
    fill_random(25000);
    drive_frame(128, 127, 1'b0);
    model_commit();
    idle(4);
    check_counts("back_to_back", d0, e0, 2, 0);
    check_bins("back_to_back");
    d0 = done_cnt; e0 = err_cnt;
    fill_random(25000);
    drive_frame(40, -1, 1'b0);
    do_reset();
    idle(4);
    check_counts("mid_reset", d0, e0, 0, 0);
    check_bins("mid_reset");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_random_frames();
    test_saturation();
    test_decay();
    test_early_eop();
    test_restart();
    test_overflow();
    test_sop_eop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
